// File: rtl/id_fwd_stage.sv
// id_fwd_stage: decode-stage front end.
//   Holds the IF/ID pipeline register and keeps the ID instruction stable
//   across stalls. Forwards rs/rt from NUM_FWD younger stages, where source 0
//   is the youngest and has the highest priority. Raises load-use stall
//   requests. Resolves MIPS branches/jumps in ID and tracks delay-slot status.
//
// Optional feature: define ID_FWD_PERF_CNT_EN to add the stall and
// taken-branch performance counters. When it is undefined, both counter
// outputs are tied to 0 and no counter flops are built.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall[5:0]          pipeline stall bus (bit1 IF/ID register, bit2 ID stage)
//   if_valid_i/if_pc_i  fetch valid and fetch PC
//   inst_i              instruction SRAM read data, arriving in the ID cycle
//   rf_raddr*_o         register-file read addresses (rs, rt)
//   rf_rdata*_i         register-file read data
//   fwd_bus_i           per source {is_load, we, waddr[4:0], wdata}; source 0 in LSBs
//   id_valid_o/id_pc_o  ID stage valid and PC
//   id_inst_o           stable ID instruction (0 when ID is not valid)
//   src1_o/src2_o       forwarded rs/rt operand values
//   stallreq_o          load-use stall request
//   br_taken_o          redirect fetch
//   br_target_o         redirect address
//   in_delayslot_o      ID instruction is a delay slot
//   perf_*_cnt_o        performance counters (optional)
module id_fwd_stage #(
  parameter int unsigned        DW              = 32,
  parameter int unsigned        NUM_FWD         = 2,
  parameter logic [NUM_FWD-1:0] LOAD_STALL_MASK = NUM_FWD'(1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                stall,
  input  logic                      if_valid_i,
  input  logic [DW-1:0]             if_pc_i,
  input  logic [31:0]               inst_i,
  output logic [4:0]                rf_raddr1_o,
  output logic [4:0]                rf_raddr2_o,
  input  logic [DW-1:0]             rf_rdata1_i,
  input  logic [DW-1:0]             rf_rdata2_i,
  input  logic [NUM_FWD*(DW+7)-1:0] fwd_bus_i,
  output logic                      id_valid_o,
  output logic [DW-1:0]             id_pc_o,
  output logic [31:0]               id_inst_o,
  output logic [DW-1:0]             src1_o,
  output logic [DW-1:0]             src2_o,
  output logic                      stallreq_o,
  output logic                      br_taken_o,
  output logic [DW-1:0]             br_target_o,
  output logic                      in_delayslot_o,
  output logic [31:0]               perf_stall_cnt_o,
  output logic [31:0]               perf_br_cnt_o
);

  localparam int unsigned FW = DW + 7;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  typedef struct packed {
    logic          is_load;
    logic          we;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
  } fwd_src_t;

  // State
  logic          valid_q,     valid_d;
  logic [DW-1:0] pc_q,        pc_d;
  logic          hold_vld_q,  hold_vld_d;
  logic [31:0]   inst_hold_q, inst_hold_d;
  logic          ds_pend_q,   ds_pend_d;
  logic          in_ds_q,     in_ds_d;

  // Combinational internals
  fwd_src_t      src [NUM_FWD];
  logic [31:0]   inst_c;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [DW-1:0] src1_c;
  logic [DW-1:0] src2_c;
  logic          uses_rt;
  logic          load_hit;
  logic          stallreq_c;
  logic          is_ctl;
  logic          cond;
  logic [DW-1:0] tgt;
  logic [DW-1:0] pc4;
  logic          br_taken_c;
  logic          br_leave;
  logic          flag_eff;
  logic          unused_stall_bits;

  assign unused_stall_bits = ^{stall[5:3], stall[0]};

  // Unpack the forwarding bus
  always_comb begin
    for (int i = 0; i < int'(NUM_FWD); i++) begin
      src[i] = fwd_bus_i[i*FW +: FW];
    end
  end

  // Effective ID instruction: the held copy wins while a stall is being held
  always_comb begin
    inst_c = 32'd0;
    if (valid_q) inst_c = hold_vld_q ? inst_hold_q : inst_i;
  end

  assign opcode = inst_c[31:26];
  assign funct  = inst_c[5:0];
  assign rs     = inst_c[25:21];
  assign rt     = inst_c[20:16];

  // Operand forwarding: scan from oldest to youngest so the youngest match wins
  always_comb begin
    src1_c = rf_rdata1_i;
    src2_c = rf_rdata2_i;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (src[i].we && (src[i].waddr == rs)) src1_c = src[i].wdata;
      if (src[i].we && (src[i].waddr == rt)) src2_c = src[i].wdata;
    end
    if (rs == 5'd0) src1_c = '0;
    if (rt == 5'd0) src2_c = '0;
  end

  // Load-use hazard; rt only counts for instructions that actually read it
  always_comb begin
    uses_rt  = (opcode == OP_SPECIAL) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
               (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SWL) ||
               (opcode == OP_SW) || (opcode == OP_SWR);
    load_hit = 1'b0;
    for (int i = 0; i < int'(NUM_FWD); i++) begin
      if (LOAD_STALL_MASK[i] && src[i].is_load && src[i].we && (src[i].waddr != 5'd0) &&
          ((src[i].waddr == rs) || (uses_rt && (src[i].waddr == rt)))) begin
        load_hit = 1'b1;
      end
    end
    stallreq_c = valid_q & load_hit;
  end

  assign pc4 = pc_q + DW'(4);

  // Branch / jump resolution
  always_comb begin
    is_ctl = 1'b0;
    cond   = 1'b0;
    tgt    = pc4 + {{(DW-18){inst_c[15]}}, inst_c[15:0], 2'b00};
    case (opcode)
      OP_SPECIAL: begin
        if ((funct == FN_JR) || (funct == FN_JALR)) begin
          is_ctl = 1'b1;
          cond   = 1'b1;
          tgt    = src1_c;
        end
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BLTZAL: begin
            is_ctl = 1'b1;
            cond   = src1_c[DW-1];
          end
          RT_BGEZ, RT_BGEZAL: begin
            is_ctl = 1'b1;
            cond   = ~src1_c[DW-1];
          end
          default: ;
        endcase
      end
      OP_J, OP_JAL: begin
        is_ctl = 1'b1;
        cond   = 1'b1;
        tgt    = {pc4[DW-1:28], inst_c[25:0], 2'b00};
      end
      OP_BEQ: begin
        is_ctl = 1'b1;
        cond   = (src1_c == src2_c);
      end
      OP_BNE: begin
        is_ctl = 1'b1;
        cond   = (src1_c != src2_c);
      end
      OP_BLEZ: begin
        is_ctl = 1'b1;
        cond   = src1_c[DW-1] | (src1_c == '0);
      end
      OP_BGTZ: begin
        is_ctl = 1'b1;
        cond   = ~src1_c[DW-1] & (src1_c != '0);
      end
      default: ;
    endcase
    br_taken_c = valid_q & ~stallreq_c & cond;
  end

  // Next state: IF/ID register, instruction hold, delay-slot tracking
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    hold_vld_d  = hold_vld_q;
    inst_hold_d = inst_hold_q;
    in_ds_d     = in_ds_q;
    // A branch leaving ID arms the flag even if the slot loads at the same edge
    br_leave    = valid_q & is_ctl & ~stall[2] & ~stallreq_c;
    flag_eff    = ds_pend_q | br_leave;
    ds_pend_d   = flag_eff;

    if (stall[1] && !stall[2]) begin
      valid_d = 1'b0;
      pc_d    = '0;
      in_ds_d = 1'b0;
    end else if (!stall[1]) begin
      valid_d = if_valid_i;
      pc_d    = if_pc_i;
      in_ds_d = if_valid_i & flag_eff;
      if (if_valid_i) ds_pend_d = 1'b0;
    end

    if (!stall[2]) begin
      hold_vld_d = 1'b0;
    end else if (!hold_vld_q) begin
      hold_vld_d  = 1'b1;
      inst_hold_d = inst_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      hold_vld_q  <= 1'b0;
      inst_hold_q <= '0;
      ds_pend_q   <= 1'b0;
      in_ds_q     <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      hold_vld_q  <= hold_vld_d;
      inst_hold_q <= inst_hold_d;
      ds_pend_q   <= ds_pend_d;
      in_ds_q     <= in_ds_d;
    end
  end

  assign rf_raddr1_o    = rs;
  assign rf_raddr2_o    = rt;
  assign id_valid_o     = valid_q;
  assign id_pc_o        = pc_q;
  assign id_inst_o      = inst_c;
  assign src1_o         = src1_c;
  assign src2_o         = src2_c;
  assign stallreq_o     = stallreq_c;
  assign br_taken_o     = br_taken_c;
  assign br_target_o    = br_taken_c ? tgt : '0;
  assign in_delayslot_o = in_ds_q;

`ifdef ID_FWD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_br_q,    perf_br_d;

  // Free-running event counters, wrapping at 2^32
  always_comb begin
    perf_stall_d = perf_stall_q + 32'(stallreq_c);
    perf_br_d    = perf_br_q + 32'(br_taken_c & ~stall[2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_br_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_br_q    <= perf_br_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_br_cnt_o    = perf_br_q;
`else
  assign perf_stall_cnt_o = 32'd0;
  assign perf_br_cnt_o    = 32'd0;
`endif

endmodule

// File: tb/tb_id_fwd_stage.sv
// tb_id_fwd_stage: directed bench for id_fwd_stage with an instruction-level
// reference model compared on every negative clock edge, plus literal
// expectations at the points of interest.
module tb_id_fwd_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned NF = 2;

  typedef enum int {K_OTHER, K_BEQ, K_BNE, K_BLEZ, K_BGTZ, K_BLTZ, K_BGEZ, K_J, K_JR} kind_e;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] inst = '0;
  logic [31:0] rf1 = '0;
  logic [31:0] rf2 = '0;
  logic        s_load [NF];
  logic        s_we   [NF];
  logic [4:0]  s_addr [NF];
  logic [31:0] s_data [NF];
  logic [NF*(DW+7)-1:0] fwd_bus;

  logic [4:0]  raddr1, raddr2;
  logic        id_valid, stallreq, br_taken, in_ds;
  logic [31:0] id_pc, id_inst, src1, src2, br_target, perf_stall, perf_br;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = '0;
  logic        m_hold  = 1'b0;
  logic [31:0] m_held  = '0;
  logic        m_pend  = 1'b0;
  logic        m_in_ds = 1'b0;
  logic [31:0] m_cnt_stall = '0;
  logic [31:0] m_cnt_br    = '0;

  assign fwd_bus = {s_load[1], s_we[1], s_addr[1], s_data[1],
                    s_load[0], s_we[0], s_addr[0], s_data[0]};

  id_fwd_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .if_valid_i(if_valid), .if_pc_i(if_pc),
    .inst_i(inst), .rf_raddr1_o(raddr1), .rf_raddr2_o(raddr2),
    .rf_rdata1_i(rf1), .rf_rdata2_i(rf2), .fwd_bus_i(fwd_bus),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst),
    .src1_o(src1), .src2_o(src2), .stallreq_o(stallreq),
    .br_taken_o(br_taken), .br_target_o(br_target), .in_delayslot_o(in_ds),
    .perf_stall_cnt_o(perf_stall), .perf_br_cnt_o(perf_br)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic kind_e kind_of(input logic [31:0] w);
    case (w[31:26])
      6'h00: return ((w[5:0] == 6'h08) || (w[5:0] == 6'h09)) ? K_JR : K_OTHER;
      6'h01: begin
        case (w[20:16])
          5'h00, 5'h10: return K_BLTZ;
          5'h01, 5'h11: return K_BGEZ;
          default:      return K_OTHER;
        endcase
      end
      6'h02, 6'h03: return K_J;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h06: return K_BLEZ;
      6'h07: return K_BGTZ;
      default: return K_OTHER;
    endcase
  endfunction

  function automatic logic [31:0] fwd_pick(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    for (int i = 0; i < NF; i++) begin
      if (s_we[i] && (s_addr[i] == a)) return s_data[i];
    end
    return rf;
  endfunction

  // What the ID stage must present given model state and current inputs
  task automatic model_eval(output logic [31:0] e_inst, output logic [31:0] e_s1,
                            output logic [31:0] e_s2, output logic e_stall,
                            output logic e_taken, output logic [31:0] e_tgt,
                            output logic e_ctl);
    logic [NF-1:0] mask;
    logic [5:0]    op;
    logic          reads_rt;
    logic          cond;
    logic [31:0]   tgt;
    logic [31:0]   pc4;
    int            s1v;
    int            off;
    kind_e         k;
    mask   = 2'b01;
    e_inst = !m_valid ? 32'd0 : (m_hold ? m_held : inst);
    op     = e_inst[31:26];
    e_s1   = fwd_pick(e_inst[25:21], rf1);
    e_s2   = fwd_pick(e_inst[20:16], rf2);
    reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h28) ||
               (op == 6'h29) || (op == 6'h2A) || (op == 6'h2B) || (op == 6'h2E);
    e_stall = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (mask[i] && s_load[i] && s_we[i] && (s_addr[i] != 5'd0) &&
          ((s_addr[i] == e_inst[25:21]) || (reads_rt && (s_addr[i] == e_inst[20:16]))))
        e_stall = m_valid;
    end
    k    = kind_of(e_inst);
    s1v  = $signed(e_s1);
    off  = $signed(e_inst[15:0]);
    pc4  = m_pc + 32'd4;
    tgt  = pc4 + 32'(off * 4);
    cond = 1'b0;
    case (k)
      K_BEQ:  cond = (e_s1 == e_s2);
      K_BNE:  cond = (e_s1 != e_s2);
      K_BLEZ: cond = (s1v <= 0);
      K_BGTZ: cond = (s1v > 0);
      K_BLTZ: cond = (s1v < 0);
      K_BGEZ: cond = (s1v >= 0);
      K_J:    begin cond = 1'b1; tgt = {pc4[31:28], e_inst[25:0], 2'b00}; end
      K_JR:   begin cond = 1'b1; tgt = e_s1; end
      default: ;
    endcase
    e_ctl   = (k != K_OTHER);
    e_taken = m_valid && !e_stall && cond;
    e_tgt   = e_taken ? tgt : 32'd0;
  endtask

  // Model state update
  always @(posedge clk or posedge rst) begin : model_upd
    logic [31:0] e_inst, e_s1, e_s2, e_tgt;
    logic        e_stall, e_taken, e_ctl, pend;
    if (rst) begin
      m_valid = 1'b0; m_pc = '0; m_hold = 1'b0; m_held = '0;
      m_pend = 1'b0; m_in_ds = 1'b0; m_cnt_stall = '0; m_cnt_br = '0;
    end else begin
      model_eval(e_inst, e_s1, e_s2, e_stall, e_taken, e_tgt, e_ctl);
      pend = m_pend || (m_valid && e_ctl && !stall[2] && !e_stall);
      if (e_stall) m_cnt_stall = m_cnt_stall + 1;
      if (e_taken && !stall[2]) m_cnt_br = m_cnt_br + 1;
      if (!stall[2]) m_hold = 1'b0;
      else if (!m_hold) begin m_held = inst; m_hold = 1'b1; end
      m_pend = pend;
      if (stall[1] && !stall[2]) begin
        m_valid = 1'b0; m_pc = '0; m_in_ds = 1'b0;
      end else if (!stall[1]) begin
        m_valid = if_valid; m_pc = if_pc;
        m_in_ds = if_valid && pend;
        if (if_valid) m_pend = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    logic [31:0] e_inst, e_s1, e_s2, e_tgt;
    logic        e_stall, e_taken, e_ctl;
    model_eval(e_inst, e_s1, e_s2, e_stall, e_taken, e_tgt, e_ctl);
    chk("cyc_id_valid",  32'(id_valid),  32'(m_valid));
    chk("cyc_id_pc",     id_pc,          m_pc);
    chk("cyc_id_inst",   id_inst,        e_inst);
    chk("cyc_raddr1",    32'(raddr1),    32'(e_inst[25:21]));
    chk("cyc_raddr2",    32'(raddr2),    32'(e_inst[20:16]));
    chk("cyc_src1",      src1,           e_s1);
    chk("cyc_src2",      src2,           e_s2);
    chk("cyc_stallreq",  32'(stallreq),  32'(e_stall));
    chk("cyc_br_taken",  32'(br_taken),  32'(e_taken));
    chk("cyc_br_target", br_target,      e_tgt);
    chk("cyc_in_ds",     32'(in_ds),     32'(m_in_ds));
`ifdef ID_FWD_PERF_CNT_EN
    chk("cyc_perf_stall", perf_stall, m_cnt_stall);
    chk("cyc_perf_br",    perf_br,    m_cnt_br);
`else
    chk("cyc_perf_stall", perf_stall, 32'd0);
    chk("cyc_perf_br",    perf_br,    32'd0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic ld, input logic we,
                         input logic [4:0] a, input logic [31:0] d);
    s_load[i] = ld; s_we[i] = we; s_addr[i] = a; s_data[i] = d;
  endtask

  task automatic set_if(input logic v, input logic [31:0] pc);
    if_valid = v; if_pc = pc;
  endtask

  initial begin
    set_src(0, 1'b0, 1'b0, 5'd0, 32'd0);
    set_src(1, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 rst = 1'b1;
    step(); step();
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_inst",  id_inst,       32'd0);
    chk("rst_in_ds",    32'(in_ds),    32'd0);
    rst = 1'b0;
    set_if(1'b1, 32'h100);

    // Forwarding priority: addu $2,$8,$0
    step();
    inst = 32'h01001021;
    set_src(0, 1'b0, 1'b1, 5'd8, 32'h11);
    set_src(1, 1'b0, 1'b1, 5'd8, 32'h22);
    rf1 = 32'h33; rf2 = 32'h33;
    set_if(1'b1, 32'h104);
    #1;
    chk("fwd_src1",   src1,         32'h11);
    chk("fwd_src2",   src2,         32'h0);
    chk("fwd_raddr1", 32'(raddr1),  32'd8);

    // Load-use: add $3,$9,$4 behind lw $9
    step();
    inst = 32'h01241820;
    set_src(0, 1'b1, 1'b1, 5'd9, 32'hAA);
    set_src(1, 1'b0, 1'b0, 5'd0, 32'h0);
    rf1 = 32'h44; rf2 = 32'h55;
    stall = 6'b000111;
    set_if(1'b1, 32'h108);
    #1;
    chk("lu_stallreq", 32'(stallreq), 32'd1);
    chk("lu_br_taken", 32'(br_taken), 32'd0);
    step();
    set_src(0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_src(1, 1'b1, 1'b1, 5'd9, 32'hAA);
    stall = 6'b000000;
    #1;
    chk("lu2_stallreq", 32'(stallreq), 32'd0);
    chk("lu2_src1",     src1,          32'hAA);
    chk("lu2_src2",     src2,          32'h55);
    chk("lu2_inst",     id_inst,       32'h01241820);

    // Stall hold across changing SRAM data
    step();
    inst = 32'h24020005;
    set_src(1, 1'b0, 1'b0, 5'd0, 32'h0);
    stall = 6'b000110;
    set_if(1'b1, 32'h10C);
    #1 chk("hold_0", id_inst, 32'h24020005);
    step(); inst = 32'hFFFFFFFF;
    #1 chk("hold_1", id_inst, 32'h24020005);
    step(); inst = 32'h00000000;
    #1 chk("hold_2", id_inst, 32'h24020005);
    step(); stall = 6'b000000;
    step();
    inst = 32'h3C01ABCD;
    set_src(0, 1'b1, 1'b1, 5'd1, 32'h5);
    set_src(1, 1'b0, 1'b1, 5'd0, 32'h99);
    set_if(1'b1, 32'h1000);
    #1;
    chk("rel_inst",        id_inst,       32'h3C01ABCD);
    chk("rel_pc",          id_pc,         32'h10C);
    chk("lui_no_rt_stall", 32'(stallreq), 32'd0);
    chk("zero_reg_src1",   src1,          32'd0);

    // Signed branches: bltz then bgtz on 0x80000000
    step();
    inst = 32'h04A00004;
    set_src(0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_src(1, 1'b0, 1'b0, 5'd0, 32'h0);
    rf1 = 32'h80000000;
    set_if(1'b1, 32'h1004);
    #1;
    chk("bltz_taken",  32'(br_taken), 32'd1);
    chk("bltz_target", br_target,     32'h1014);
    step();
    inst = 32'h1CA00004;
    set_if(1'b1, 32'h1008);
    #1;
    chk("bgtz_taken",  32'(br_taken), 32'd0);
    chk("bgtz_target", br_target,     32'd0);
    chk("bgtz_in_ds",  32'(in_ds),    32'd1);
    step();
    inst = 32'h3C01ABCD;
    set_if(1'b1, 32'h2000);
    #1 chk("after_bgtz_in_ds", 32'(in_ds), 32'd1);

    // beq equal, negative offset
    step();
    inst = 32'h1085FFFF;
    rf1 = 32'h7; rf2 = 32'h7;
    set_if(1'b1, 32'h2004);
    #1;
    chk("beq_taken",  32'(br_taken), 32'd1);
    chk("beq_target", br_target,     32'h2000);
    chk("beq_in_ds",  32'(in_ds),    32'd0);

    // jr $31 with the target forwarded from source 1
    step();
    inst = 32'h03E00008;
    rf1 = 32'h1;
    set_src(1, 1'b0, 1'b1, 5'd31, 32'h80000180);
    set_if(1'b1, 32'hBFC00010);
    #1;
    chk("jr_target", br_target,  32'h80000180);
    chk("jr_in_ds",  32'(in_ds), 32'd1);

    // jal, then a bubble, then the delay slot
    step();
    inst = 32'h0C000100;
    set_src(1, 1'b0, 1'b0, 5'd0, 32'h0);
    set_if(1'b0, 32'h0);
    #1;
    chk("jal_taken",  32'(br_taken), 32'd1);
    chk("jal_target", br_target,     32'hB0000400);
    step();
    inst = 32'h3C01ABCD;
    set_if(1'b1, 32'hBFC00018);
    #1;
    chk("bubble_valid", 32'(id_valid), 32'd0);
    chk("bubble_inst",  id_inst,       32'd0);
    chk("bubble_in_ds", 32'(in_ds),    32'd0);
    step();
    set_if(1'b1, 32'hBFC0001C);
    #1 chk("slot_in_ds", 32'(in_ds), 32'd1);
    step();
    set_if(1'b1, 32'h3000);
    #1 chk("post_slot_in_ds", 32'(in_ds), 32'd0);

    // Async reset in the middle of a held stall
    step();
    inst = 32'h24020005;
    stall = 6'b000110;
    step();
    inst = 32'hFFFFFFFF;
    #1 chk("pre_rst_hold", id_inst, 32'h24020005);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid",      32'(id_valid), 32'd0);
    chk("arst_pc",         id_pc,         32'd0);
    chk("arst_inst",       id_inst,       32'd0);
    chk("arst_src1",       src1,          32'd0);
    chk("arst_stallreq",   32'(stallreq), 32'd0);
    chk("arst_br_taken",   32'(br_taken), 32'd0);
    chk("arst_br_target",  br_target,     32'd0);
    chk("arst_in_ds",      32'(in_ds),    32'd0);
    chk("arst_perf_stall", perf_stall,    32'd0);
    chk("arst_perf_br",    perf_br,       32'd0);
    step(); step();
    rst = 1'b0;
    stall = 6'b000000;
    set_if(1'b1, 32'h3004);
    step();
    inst = 32'h3C01ABCD;
    #1;
    chk("post_rst_inst", id_inst, 32'h3C01ABCD);
    chk("post_rst_pc",   id_pc,   32'h3004);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
